// File: rtl/euler1_pkg.sv
// Shared constants, state encoding and golden value for the Euler-1 tile readout.
package euler1_pkg;
    localparam int SLICE_W       = 6;
    localparam int NUM_SLICES    = 3;
    localparam int RES_W         = SLICE_W * NUM_SLICES;
    localparam int DIGITS        = 6;
    localparam int BCD_W         = 4 * DIGITS;
    localparam int MUX_W         = 2;
    localparam int TIMEOUT_DEF   = 600;
    localparam int SETTLE_DEF    = 1;
    localparam int MAX_RETRY_DEF = 1;

    // Sum of multiples of 3 or 5 below 1000: what a healthy tile reports.
    localparam logic [RES_W-1:0] GOLDEN = 18'd233168;

    typedef enum logic [2:0] {
        S_IDLE, S_TRST, S_WAIT, S_SEL, S_SAMPLE, S_CONV, S_DONE, S_FAIL
    } state_e;
endpackage

// File: rtl/euler1_readout_if.sv
// Result handshake bus: the readout controller masters it, the consumer is the slave.
interface euler1_readout_if;
    import euler1_pkg::*;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] result;
    logic [BCD_W-1:0] bcd;

    modport master (output out_valid, result, bcd, input out_ready);
    modport slave  (input out_valid, result, bcd, output out_ready);
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: the start cycle performs the first shift, done pulses
// with the final digits registered RES_W cycles after start.
module bin2bcd_seq
    import euler1_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [RES_W-1:0] bin,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);
    localparam int CW = $clog2(RES_W + 1);

    logic [BCD_W-1:0]       bcd_q, bcd_d;
    logic [RES_W-1:0]       shd_q, shd_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic [BCD_W+RES_W-1:0] step;

    function automatic logic [BCD_W+RES_W-1:0] dabble(input logic [BCD_W-1:0] b,
                                                      input logic [RES_W-1:0] s);
        logic [BCD_W-1:0] a;
        a = b;
        for (int i = 0; i < DIGITS; i++)
            if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
        return {a, s} << 1;
    endfunction

    always_comb begin
        step   = dabble(start ? '0 : bcd_q, start ? bin : shd_q);
        bcd_d  = bcd_q;
        shd_d  = shd_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (start) begin
            {bcd_d, shd_d} = step;
            cnt_d          = CW'(RES_W - 1);
        end else if (cnt_q != '0) begin
            {bcd_d, shd_d} = step;
            cnt_d          = cnt_q - 1'b1;
            done_d         = (cnt_q == CW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_q  <= '0;
            shd_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            bcd_q  <= bcd_d;
            shd_q  <= shd_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign bcd  = bcd_q;
endmodule

// File: rtl/euler1_readout.sv
// Euler-1 tile readout: reset tile, wait for valid (one retry), sweep slices,
// convert to BCD and hand the result over a valid/ready bus.
module euler1_readout
    import euler1_pkg::*;
#(
    parameter int TIMEOUT   = TIMEOUT_DEF,
    parameter int SETTLE    = SETTLE_DEF,
    parameter int MAX_RETRY = MAX_RETRY_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               tgt_valid,
    input  logic [SLICE_W-1:0] slice_in,
    output logic               tgt_rst,
    output logic [MUX_W-1:0]   mux_sel,
    output logic               busy,
    output logic               err,
    euler1_readout_if.master   out_if
);
    localparam int CNT_W = $clog2(TIMEOUT + SETTLE + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 2);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [MUX_W-1:0] idx_q, idx_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic             tgt_rst_q, tgt_rst_d;
    logic [MUX_W-1:0] mux_sel_q, mux_sel_d;
    logic             busy_q, busy_d;
    logic             out_valid_q, out_valid_d;
    logic [RES_W-1:0] result_q, result_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic             err_q, err_d;
    logic             conv_start_q, conv_start_d;
    logic             conv_done;
    logic [BCD_W-1:0] conv_bcd;

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start_q),
        .bin   (result_q),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // cnt_q is shared: wait timer in WAIT, settle timer in SEL.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        case (state_q)
            S_IDLE: if (start) begin
                retry_d = '0;
                state_d = S_TRST;
            end
            S_TRST: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (tgt_valid) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SEL;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    if (retry_q < RTY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_TRST;
                    end else begin
                        state_d = S_FAIL;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SEL: begin
                if (cnt_q == CNT_W'(SETTLE - 1)) state_d = S_SAMPLE;
                else                             cnt_d   = cnt_q + 1'b1;
            end
            S_SAMPLE: begin
                if (idx_q == MUX_W'(NUM_SLICES - 1)) begin
                    state_d = S_CONV;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    cnt_d   = '0;
                    state_d = S_SEL;
                end
            end
            S_CONV:  if (conv_done) state_d = S_DONE;
            S_DONE:  if (out_if.out_ready) state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up with it.
    always_comb begin
        tgt_rst_d    = (state_d == S_TRST);
        busy_d       = (state_d != S_IDLE);
        out_valid_d  = (state_d == S_DONE);
        mux_sel_d    = (state_d == S_SEL || state_d == S_SAMPLE) ? idx_d : '0;
        conv_start_d = (state_d == S_CONV) && (state_q != S_CONV);
        result_d     = result_q;
        bcd_d        = bcd_q;
        err_d        = err_q;
        if (state_q == S_IDLE && start) begin
            result_d = '0;
            bcd_d    = '0;
            err_d    = 1'b0;
        end
        if (state_q == S_SAMPLE) result_d[idx_q*SLICE_W +: SLICE_W] = slice_in;
        if (state_q == S_CONV && conv_done) bcd_d = conv_bcd;
        if (state_d == S_FAIL) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            retry_q      <= '0;
            tgt_rst_q    <= 1'b0;
            mux_sel_q    <= '0;
            busy_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            result_q     <= '0;
            bcd_q        <= '0;
            err_q        <= 1'b0;
            conv_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            retry_q      <= retry_d;
            tgt_rst_q    <= tgt_rst_d;
            mux_sel_q    <= mux_sel_d;
            busy_q       <= busy_d;
            out_valid_q  <= out_valid_d;
            result_q     <= result_d;
            bcd_q        <= bcd_d;
            err_q        <= err_d;
            conv_start_q <= conv_start_d;
        end
    end

    assign tgt_rst          = tgt_rst_q;
    assign mux_sel          = mux_sel_q;
    assign busy             = busy_q;
    assign err              = err_q;
    assign out_if.out_valid = out_valid_q;
    assign out_if.result    = result_q;
    assign out_if.bcd       = bcd_q;
endmodule

// File: tb/tb_euler1_readout.sv
// Directed bench for euler1_readout: tile model, monitor and a result scoreboard.
module tb_euler1_readout;
    import euler1_pkg::*;

    typedef struct packed {
        logic [RES_W-1:0] res;
        logic [BCD_W-1:0] bcd;
        logic             err;
    } exp_t;

    logic               clk;
    logic               rst;
    logic               start;
    logic               tgt_valid = 1'b0;
    logic [SLICE_W-1:0] slice_in;
    logic               tgt_rst;
    logic [MUX_W-1:0]   mux_sel;
    logic               busy;
    logic               err;
    logic               out_ready;

    euler1_readout_if out_if ();
    assign out_if.out_ready = out_ready;

    euler1_readout dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tgt_valid (tgt_valid),
        .slice_in  (slice_in),
        .tgt_rst   (tgt_rst),
        .mux_sel   (mux_sel),
        .busy      (busy),
        .err       (err),
        .out_if    (out_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    // Tile model: delay per attempt (-1 = never valid), slices taken from tile_val.
    logic [RES_W-1:0] tile_val;
    int tile_delay[2];
    int tile_att = 0;
    int tile_idx = 0;
    int tile_cnt = 0;
    bit tile_on  = 1'b0;

    always @(posedge clk) begin
        if (busy !== 1'b1) begin
            tile_att  <= 0;
            tile_on   <= 1'b0;
            tile_cnt  <= 0;
            tgt_valid <= 1'b0;
        end else if (tgt_rst) begin
            tile_idx  <= (tile_att > 1) ? 1 : tile_att;
            tile_att  <= tile_att + 1;
            tile_on   <= 1'b1;
            tile_cnt  <= 0;
            tgt_valid <= 1'b0;
        end else if (tile_on) begin
            tile_cnt  <= tile_cnt + 1;
            tgt_valid <= (tile_delay[tile_idx] >= 0) && (tile_cnt + 1 >= tile_delay[tile_idx]);
        end
    end

    always_comb begin
        case (mux_sel)
            2'd0:    slice_in = tile_val[5:0];
            2'd1:    slice_in = tile_val[11:6];
            2'd2:    slice_in = tile_val[17:12];
            default: slice_in = '0;
        endcase
    end

    // Monitor; after edge n, cyc == n, events are tagged with the edge that produced them.
    int cyc = 0;
    int n_trst = 0, trst_last = 0, trst_prev = 0;
    int vs_cyc = 0, ov_cyc = 0, err_cyc = 0;
    int n_ov = 0, n_mux = 0;
    bit tv_prev = 1'b0, ov_prev = 1'b0, er_prev = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tgt_rst === 1'b1) begin
            n_trst    <= n_trst + 1;
            trst_prev <= trst_last;
            trst_last <= cyc;
        end
        if (tgt_valid && !tv_prev) vs_cyc <= cyc + 1;
        if (out_if.out_valid === 1'b1 && !ov_prev) ov_cyc <= cyc;
        if (err === 1'b1 && !er_prev) err_cyc <= cyc;
        if (out_if.out_valid === 1'b1) n_ov <= n_ov + 1;
        if (mux_sel !== '0) n_mux <= n_mux + 1;
        tv_prev <= tgt_valid;
        ov_prev <= (out_if.out_valid === 1'b1);
        er_prev <= (err === 1'b1);
    end

    function automatic logic [BCD_W-1:0] to_bcd(input int v);
        logic [BCD_W-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input logic [RES_W-1:0] res, input logic e);
        exp_t x;
        x.res = res;
        x.bcd = e ? '0 : to_bcd(int'(res));
        x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_tgt_rst"}, 32'(tgt_rst), 0);
        chk({tag, "_mux_sel"}, 32'(mux_sel), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_out_valid"}, 32'(out_if.out_valid), 0);
        chk({tag, "_result"}, 32'(out_if.result), 0);
        chk({tag, "_bcd"}, 32'(out_if.bcd), 0);
        chk({tag, "_err"}, 32'(err), 0);
    endtask

    task automatic pop_exp(input string tag, output exp_t e);
        chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 1);
        e = '0;
        if (exp_q.size() != 0) e = exp_q.pop_front();
    endtask

    task automatic collect(input string tag, input int hold, input bit poke);
        exp_t e;
        int   k;
        k = 0;
        while (out_if.out_valid !== 1'b1 && k < 4000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_out_valid"}, 32'(out_if.out_valid), 1);
        pop_exp(tag, e);
        chk({tag, "_result"}, 32'(out_if.result), 32'(e.res));
        chk({tag, "_bcd"}, 32'(out_if.bcd), 32'(e.bcd));
        chk({tag, "_err"}, 32'(err), 32'(e.err));
        for (int i = 0; i < hold; i++) begin
            if (poke && i == hold / 2) start = 1'b1;
            @(negedge clk);
            if (poke) start = 1'b0;
            chk({tag, "_hold_valid"}, 32'(out_if.out_valid), 1);
            chk({tag, "_hold_bcd"}, 32'(out_if.bcd), 32'(e.bcd));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(out_if.out_valid), 0);
    endtask

    task automatic collect_fail(input string tag);
        exp_t e;
        int   k;
        k = 0;
        while (err !== 1'b1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_err_set"}, 32'(err), 1);
        pop_exp(tag, e);
        chk({tag, "_err"}, 32'(err), 32'(e.err));
        chk({tag, "_result"}, 32'(out_if.result), 32'(e.res));
        @(negedge clk);
        chk({tag, "_idle"}, 32'(busy), 0);
        chk({tag, "_err_sticky"}, 32'(err), 1);
    endtask

    initial begin
        int t0, m0, o0, c0, k;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        tile_val = '0; tile_delay = '{-1, -1};
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst = 1'b0;
        @(negedge clk);

        // Nominal readout, valid 300 cycles after tile reset.
        tile_val = GOLDEN; tile_delay = '{300, 300};
        t0 = n_trst;
        start = 1'b1; expect_out(GOLDEN, 1'b0);
        @(negedge clk); start = 1'b0;
        collect("t1", 0, 1'b0);
        chk("t1_bcd_const", 32'(out_if.bcd), 32'h233168);
        chk("t1_result_held", 32'(out_if.result), 233168);
        chk("t1_idle", 32'(busy), 0);
        chk("t1_latency", 32'(ov_cyc - vs_cyc), 25);
        chk("t1_trst_count", 32'(n_trst - t0), 1);

        // First attempt times out, second sees valid after 10 cycles.
        tile_delay = '{-1, 10};
        t0 = n_trst;
        start = 1'b1; expect_out(GOLDEN, 1'b0);
        @(negedge clk); start = 1'b0;
        collect("t2", 0, 1'b0);
        chk("t2_trst_count", 32'(n_trst - t0), 2);
        chk("t2_trst_gap", 32'(trst_last - trst_prev), 601);

        // Tile never responds.
        tile_delay = '{-1, -1};
        t0 = n_trst; m0 = n_mux; o0 = n_ov; c0 = cyc;
        start = 1'b1; expect_out('0, 1'b1);
        @(negedge clk); start = 1'b0;
        collect_fail("t3");
        @(negedge clk);
        chk("t3_fail_cycle", 32'(err_cyc - (c0 + 1)), 1202);
        chk("t3_mux_quiet", 32'(n_mux - m0), 0);
        chk("t3_no_valid", 32'(n_ov - o0), 0);
        chk("t3_trst_count", 32'(n_trst - t0), 2);

        // All-ones slices, consumer stalls 20 cycles, start poked during DONE.
        tile_val = 18'h3FFFF; tile_delay = '{5, 5};
        start = 1'b1; expect_out(18'h3FFFF, 1'b0);
        @(negedge clk); start = 1'b0;
        chk("t4_err_clear", 32'(err), 0);
        collect("t4", 20, 1'b1);
        chk("t4_bcd_const", 32'(out_if.bcd), 32'h262143);
        @(negedge clk);
        chk("t4_start_ignored", 32'(busy), 0);

        // Reset during conversion, then a clean readout.
        tile_val = GOLDEN; tile_delay = '{20, 20};
        start = 1'b1; expect_out(GOLDEN, 1'b0);
        @(negedge clk); start = 1'b0;
        k = 0;
        while (tgt_valid !== 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("t5_tile_valid", 32'(tgt_valid), 1);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset("t5_rst");
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        start = 1'b1; expect_out(GOLDEN, 1'b0);
        @(negedge clk); start = 1'b0;
        collect("t5", 0, 1'b0);

        // Zero slices with start held high: back-to-back readouts.
        tile_val = '0; tile_delay = '{3, 3};
        start = 1'b1; expect_out('0, 1'b0); expect_out('0, 1'b0);
        collect("t6a", 0, 1'b0);
        chk("t6_gap_idle", 32'(busy), 0);
        @(negedge clk);
        chk("t6_restart_busy", 32'(busy), 1);
        chk("t6_restart_trst", 32'(tgt_rst), 1);
        start = 1'b0;
        collect("t6b", 0, 1'b0);
        @(negedge clk);
        chk("t6_end_idle", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/euler1_readout.md
# euler1_readout

Harness-side readout controller for the Euler-1 accumulator tile. It resets the tile and waits for its `valid` flag, retrying once on timeout. It then sweeps the tile's 2-bit slice select to gather the 18-bit result in three 6-bit slices, converts the result to six BCD digits with a sequential double-dabble, and presents both under a valid/ready handshake. It sits directly downstream of the tile's `io_out` bus and drives the tile's reset and `mux_sel` pins.

## Interface
- `SLICE_W`, 6: width of one result slice from the tile.
- `NUM_SLICES`, 3: slices per result; result width `RES_W = SLICE_W*NUM_SLICES` (18).
- `DIGITS`, 6: BCD digits produced; must satisfy 10^DIGITS > 2^RES_W.
- `TIMEOUT`, 600: cycles to wait for tile `valid` before retrying.
- `SETTLE`, 1: cycles between a `mux_sel` change and sampling of `slice_in`.
- `MAX_RETRY`, 1: tile re-resets allowed after a timeout.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high.
- `start` in 1: request one readout; accepted only in IDLE.
- `tgt_valid` in 1: tile `io_out[0]`.
- `slice_in` in SLICE_W: tile `io_out[7:2]`.
- `tgt_rst` out 1: tile reset.
- `mux_sel` out 2: tile slice select.
- `busy` out 1: high in every state except IDLE.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.
- `result` out RES_W: binary result.
- `bcd` out 4*DIGITS: packed BCD, digit 0 in bits [3:0].
- `err` out 1: sticky timeout failure flag.

## Operation
- States: IDLE, TRST, WAIT, SEL, SAMPLE, CONV, DONE, FAIL.
- IDLE: when `start`=1, clear `err`, clear the retry count, clear `result` and `bcd`, then go to TRST.
- TRST: hold `tgt_rst`=1 for exactly one cycle, clear the wait counter, then go to WAIT.
- WAIT:
  - `tgt_valid` sampled high: set slice index to 0 and go to SEL.
  - Wait counter reaches TIMEOUT-1 with `tgt_valid` still low and retry count < MAX_RETRY: increment retry count and go to TRST.
  - Same timeout with retry count = MAX_RETRY: go to FAIL.
- SEL: `mux_sel` = slice index; wait SETTLE cycles, then go to SAMPLE.
- SAMPLE:
  - Load `slice_in` into `result[idx*SLICE_W +: SLICE_W]`.
  - If idx = NUM_SLICES-1, go to CONV; otherwise increment idx and go to SEL.
  - `tgt_valid` is not rechecked during the sweep.
- CONV: double-dabble, one result bit per cycle, RES_W cycles, then go to DONE. Each cycle:
  - Add 3 to every BCD digit ≥ 5.
  - Shift {bcd, shadow result} left by one.
  - The shadow copy is consumed; the `result` output is not.
- DONE: `out_valid`=1. On `out_ready`=1, go to IDLE; `result` and `bcd` hold their values until the next `start`.
- FAIL: set `err`=1 for one cycle in this state, then go to IDLE. `err` stays set until the next accepted `start`; `out_valid` is never asserted.
- `mux_sel` returns to 0 in every state other than SEL and SAMPLE.

## Timing
- Reset values: state IDLE, `tgt_rst`=0, `mux_sel`=0, `busy`=0, `out_valid`=0, `result`=0, `bcd`=0, `err`=0.
- All outputs are registered.
- `start` sampled at edge 0:
  - TRST occupies cycle 1, with `tgt_rst` high during that cycle only.
  - WAIT begins in cycle 2.
- Readout latency from the edge that samples `tgt_valid` high to `out_valid` rising is NUM_SLICES*(SETTLE+1) + RES_W + 1 cycles (25 with defaults).
- Timeout path: each attempt spends 1 + TIMEOUT cycles in TRST and WAIT. With defaults, FAIL is reached 1202 cycles after `start`.
- `start` while `busy`: ignored.
- `out_ready` outside DONE: ignored.
- `out_valid` and `out_ready` high in the same cycle: transfer completes; `out_valid` is low the next cycle.
- `rst` mid-operation takes effect at the next edge and returns the block to reset values. A pending `tgt_rst` pulse is dropped.
- `tgt_valid` going high in the same cycle as the timeout: valid wins.

## Structure
- Package `euler1_pkg` holds:
  - the state enum;
  - RES_W and the BCD width derivations;
  - the `mux_sel` width constant;
  - the expected golden value 233168 for benches.
- One sub-module, `bin2bcd_seq`:
  - Ports: `start`, `bin[RES_W]`, `done`, `bcd`.
  - Behaviour: iterative double-dabble; `done` pulses after RES_W cycles.
  - Instantiated by the CONV state.

## Test plan
- Tile model asserts `tgt_valid` 300 cycles after `tgt_rst` and returns the slices of 233168 (0x38ED0, giving slices 0x10, 0x3B, 0x38) → `result`=233168, `bcd`=0x233168, `out_valid` rises 25 cycles after valid is sampled, `err`=0.
- First attempt never asserts valid; second attempt asserts valid after 10 cycles → exactly two `tgt_rst` pulses, 601 cycles apart; `result`=233168.
- Tile never asserts valid → FAIL is reached at cycle 1202, `err`=1, `out_valid` stays 0, `mux_sel` is never nonzero.
- Slices 0x3F, 0x3F, 0x3F with `out_ready` held low for 20 cycles → `result`=262143, `bcd`=0x262143 held stable, `out_valid` high until `out_ready`; `start` pulsed during DONE is ignored.
- `rst` asserted during CONV → next cycle all outputs are at reset values; a new `start` then completes normally with `result`=233168.
- All slices 0 with `start` held high continuously → `bcd`=0; back-to-back readouts begin one cycle after each `out_ready` handshake.
